// File: rtl/ps2_pkg.sv
// ps2_pkg: shared receiver state encoding and PS/2 frame constants
package ps2_pkg;
  localparam int DATA_BITS = 8;
  localparam int FRAME_LEN = 11;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;
endpackage

// File: rtl/ps2_filter.sv
// ps2_filter: 2-flop synchronizer plus glitch filter that moves the level only after FILTER_LEN equal samples
module ps2_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset_i,
  input  logic d_i,
  output logic level_o
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic meta_q, sync_q, level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      meta_q  <= d_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end
  // cnt counts consecutive samples disagreeing with the current level
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) level_d = sync_q;
      else cnt_d = cnt_q + 1'b1;
    end
  end
  assign level_o = level_q;
endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard frame receiver with glitch filtering, parity check and inter-edge timeout
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FREQ_HZ    = 1_000_000,
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT_US = 1000
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] ps2_kbd_code_o,
  output logic       ps2_kbd_strobe_o,
  output logic       ps2_kbd_err_o
);
  localparam int TIMEOUT_CYCLES = FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(DATA_BITS);
  state_e state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, code_q, code_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic par_q, par_d, strobe_q, strobe_d, err_q, err_d;
  logic clk_lvl, clk_lvl_q, dmeta_q, dsync_q;
  logic fall, timeout, stop_edge, frame_ok;
  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk    (clk),
    .reset_i(reset_i),
    .d_i    (ps2_clk_i),
    .level_o(clk_lvl)
  );
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      code_q    <= '0;
      strobe_q  <= 1'b0;
      err_q     <= 1'b0;
      clk_lvl_q <= 1'b1;
      dmeta_q   <= 1'b1;
      dsync_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      code_q    <= code_d;
      strobe_q  <= strobe_d;
      err_q     <= err_d;
      clk_lvl_q <= clk_lvl;
      dmeta_q   <= ps2_data_i;
      dsync_q   <= dmeta_q;
    end
  end
  assign fall     = clk_lvl_q & ~clk_lvl;
  assign timeout  = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES));
  assign frame_ok = dsync_q & (^{shift_q, par_q});
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = (state_q == IDLE || fall) ? '0 :
                (tmo_q == TW'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + 1'b1;
    if (timeout) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          state_d   = dsync_q ? IDLE : DATA;
          bit_cnt_d = '0;
        end
        DATA: begin
          shift_d   = {dsync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = (bit_cnt_q == BW'(DATA_BITS - 1)) ? PARITY : DATA;
        end
        PARITY: begin
          par_d   = dsync_q;
          state_d = STOP;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // timeout and stop_edge are mutually exclusive, so strobe and err never coincide
  always_comb begin
    stop_edge = fall && (state_q == STOP) && !timeout;
    strobe_d  = stop_edge & frame_ok;
    err_d     = timeout | (stop_edge & ~frame_ok);
    code_d    = strobe_d ? shift_q : code_q;
  end
  assign ps2_kbd_code_o   = code_q;
  assign ps2_kbd_strobe_o = strobe_q;
  assign ps2_kbd_err_o    = err_q;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: scoreboard bench driving PS/2 frames and checking strobe/err/code against a frame-level model
module tb_ps2_kbd_rx;
  localparam int FL = 4;
  logic clk = 1'b0, reset_i = 1'b1, ps2_clk_i = 1'b1, ps2_data_i = 1'b1;
  logic [7:0] code;
  logic strobe, err;
  typedef struct packed {logic is_err; logic [7:0] code;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  int n_tests = 0, n_fail = 0;
  logic [7:0] model_code = 8'h00;

  ps2_kbd_rx #(.FREQ_HZ(1_000_000), .FILTER_LEN(FL), .TIMEOUT_US(1000)) dut (
    .clk             (clk),
    .reset_i         (reset_i),
    .ps2_clk_i       (ps2_clk_i),
    .ps2_data_i      (ps2_data_i),
    .ps2_kbd_code_o  (code),
    .ps2_kbd_strobe_o(strobe),
    .ps2_kbd_err_o   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // a frame is good iff stop is 1 and data plus parity hold an odd number of ones
  task automatic expect_frame(input logic [7:0] d, input logic par, input logic stp);
    exp_t e;
    int ones;
    ones = par;
    for (int i = 0; i < 8; i++) ones += d[i];
    if (stp && (ones % 2 == 1)) model_code = d;
    e.is_err = !(stp && (ones % 2 == 1));
    e.code   = model_code;
    q.push_back(e);
  endtask

  task automatic send(input logic [7:0] d, input logic par, input logic stp,
                      input int half, input int nbits, input int glitch);
    logic [10:0] f;
    f = {stp, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data_i = f[i];
      if (i == glitch) begin
        cyc(half / 2);
        ps2_clk_i = 1'b0;
        cyc(FL - 2);
        ps2_clk_i = 1'b1;
        cyc(half - half / 2 - (FL - 2));
      end else cyc(half);
      ps2_clk_i = 1'b0;
      cyc(half);
      ps2_clk_i = 1'b1;
    end
    ps2_data_i = 1'b1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 300) begin
      cyc(1);
      t++;
    end
    chk("pending_responses", q.size(), 0);
    q.delete();
  endtask

  always @(negedge clk) begin
    if (strobe || err) begin
      chk("strobe_err_exclusive", int'(strobe && err), 0);
      if (q.size() == 0) chk("unexpected_pulse", int'({strobe, err}), 0);
      else begin
        mon_e = q.pop_front();
        chk("pulse_is_err", int'(err), int'(mon_e.is_err));
        chk("pulse_is_strobe", int'(strobe), int'(!mon_e.is_err));
        chk("code", int'(code), int'(mon_e.code));
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic par, stp;
    int kind, half, gl;
    cyc(3);
    chk("reset_code", code, 0);
    chk("reset_strobe", strobe, 0);
    chk("reset_err", err, 0);
    reset_i = 1'b0;
    cyc(10);
    chk("idle_code", code, 0);
    expect_frame(8'h1C, 1'b0, 1'b1);
    send(8'h1C, 1'b0, 1'b1, 40, 11, -1);
    drain();
    expect_frame(8'hF0, 1'b1, 1'b1);
    send(8'hF0, 1'b1, 1'b1, 40, 11, -1);
    expect_frame(8'h1C, 1'b0, 1'b1);
    send(8'h1C, 1'b0, 1'b1, 40, 11, -1);
    drain();
    expect_frame(8'h1C, 1'b1, 1'b1);
    send(8'h1C, 1'b1, 1'b1, 40, 11, -1);
    drain();
    expect_frame(8'h1C, 1'b0, 1'b0);
    send(8'h1C, 1'b0, 1'b0, 40, 11, -1);
    drain();
    chk("code_after_bad", code, 8'h1C);
    expect_frame(8'h00, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b1, 40, 5, -1);
    cyc(2000);
    drain();
    expect_frame(8'h5A, 1'b1, 1'b1);
    send(8'h5A, 1'b1, 1'b1, 40, 11, -1);
    drain();
    expect_frame(8'h29, 1'b0, 1'b1);
    send(8'h29, 1'b0, 1'b1, 40, 11, 4);
    drain();
    send(8'h76, 1'b0, 1'b1, 40, 6, -1);
    #2 reset_i = 1'b1;
    cyc(5);
    chk("midframe_reset_code", code, 0);
    reset_i = 1'b0;
    model_code = 8'h00;
    cyc(50);
    chk("post_reset_code", code, 0);
    expect_frame(8'h76, 1'b0, 1'b1);
    send(8'h76, 1'b0, 1'b1, 40, 11, -1);
    drain();
    for (int n = 0; n < 16; n++) begin
      d    = 8'($urandom);
      kind = $urandom_range(0, 7);
      par  = ~(^d);
      stp  = 1'b1;
      if (kind == 0) par = ~par;
      if (kind == 1) stp = 1'b0;
      half = $urandom_range(30, 60);
      gl   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : -1;
      expect_frame(d, par, stp);
      send(d, par, stp, half, 11, gl);
      drain();
      cyc($urandom_range(0, 100));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 SHALL have parameter FREQ_HZ, default 1_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter FILTER_LEN, default 4, number of consecutive equal samples required to accept a ps2_clk level change.
REQ-003 SHALL have parameter TIMEOUT_US, default 1000, maximum gap between ps2_clk falling edges inside a frame, in microseconds.
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_i, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port ps2_clk_i, input, 1, raw PS/2 clock line, asynchronous to clk.
REQ-007 SHALL have port ps2_data_i, input, 1, raw PS/2 data line, asynchronous to clk.
REQ-008 SHALL have port ps2_kbd_code_o, output, 8, last correctly received scan code byte.
REQ-009 SHALL have port ps2_kbd_strobe_o, output, 1, one-cycle pulse when ps2_kbd_code_o is updated.
REQ-010 SHALL have port ps2_kbd_err_o, output, 1, one-cycle pulse on a framing, parity or timeout error.

Function
REQ-011 SHALL pass ps2_clk_i and ps2_data_i each through a 2-flop synchronizer before any use.
REQ-012 SHALL change the filtered clock level only after FILTER_LEN consecutive identical synchronized samples; shorter pulses SHALL be ignored.
REQ-013 SHALL detect a falling edge as a filtered-level transition from 1 to 0 and sample synchronized data in that same cycle.
REQ-014 SHALL use frame format: start bit 0, 8 data bits LSB first, odd parity bit, stop bit 1.
REQ-015 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-016 In IDLE, SHALL go to DATA with bit count 0 on a falling edge with data 0, and SHALL stay in IDLE with no error if data is 1.
REQ-017 In DATA, SHALL shift in one bit per falling edge and go to PARITY after the 8th bit.
REQ-018 In PARITY, SHALL capture the parity bit on the next falling edge and go to STOP.
REQ-019 In STOP, on the next falling edge SHALL return to IDLE and evaluate the frame: stop==1 and the XOR of the 8 data bits and parity equal to 1 means good, anything else is an error.
REQ-020 For a good frame, SHALL load ps2_kbd_code_o and pulse ps2_kbd_strobe_o exactly one cycle, both in the cycle after the stop-bit edge is detected.
REQ-021 For a bad frame, SHALL pulse ps2_kbd_err_o one cycle with the same latency, SHALL NOT pulse strobe, and SHALL leave ps2_kbd_code_o unchanged.
REQ-022 SHALL use timeout limit TIMEOUT_CYCLES = FREQ_HZ/1_000_000*TIMEOUT_US, computed at elaboration.
REQ-023 SHALL clear the timeout counter on every falling edge and hold it at 0 in IDLE; it SHALL saturate, never wrap.
REQ-024 Outside IDLE, when the counter reaches TIMEOUT_CYCLES, SHALL go to IDLE, pulse ps2_kbd_err_o once, and discard partial data.
REQ-025 Strobe and err SHALL never be asserted in the same cycle.

Reset
REQ-026 On reset_i, SHALL immediately set state IDLE, ps2_kbd_code_o 0x00, strobe 0, err 0, counters 0, shift register 0, and synchronizer/filter flops 1 (idle line level).
REQ-027 SHALL produce no strobe or error for a frame interrupted by reset, and SHALL accept the next complete frame normally.

Structure
REQ-028 SHALL define the state enum and frame constants (DATA_BITS=8, frame length 11) in shared package ps2_pkg.
REQ-029 SHALL place the synchronizer and glitch filter in sub-module ps2_filter (parameter FILTER_LEN), instantiated for ps2_clk_i; ps2_data_i SHALL use only the 2-flop synchronizer.

Verification
REQ-030 Frame 0x1C with parity 0 at a 12.5 kHz PS/2 clock -> one strobe, code 0x1C, no err.
REQ-031 Frames 0xF0 then 0x1C back-to-back -> two strobes, codes 0xF0 then 0x1C in order.
REQ-032 Frame 0x1C with parity 1, and separately with stop bit 0 -> one err pulse each, no strobe, code still holds its previous value.
REQ-033 After 5 bits, ps2_clk held high for 2 ms -> one err pulse and return to IDLE; a following 0x5A frame with parity 1 -> strobe, code 0x5A.
REQ-034 A glitch on ps2_clk shorter than FILTER_LEN cycles mid-frame -> ignored; frame 0x29 still received correctly.
REQ-035 reset_i asserted mid-frame, then a 0x76 frame -> no pulse during reset, then strobe with code 0x76.
